// File: rtl/iomem_arbiter.sv
// ----------------------------------------------------------------------------
// iomem_arbiter
//
// Two-master, one-slave arbiter for the picorv32-style iomem bus
// (valid/ready handshake, wstrb == 0 means read). The CPU iomem port (m0)
// and a secondary master such as a DMA or frame engine (m1) share one
// memory-mapped slave window.
//
// Arbitration is round-robin with exactly one transaction per grant. A
// watchdog force-completes a transaction that the slave never acknowledges.
// The master then gets a recognisable error word and timeout_err pulses.
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   m0_valid     master 0 request, held with addr/wdata/wstrb until m0_ready
//   m0_ready     master 0 completion strobe (one cycle)
//   m0_wstrb     master 0 byte write strobes, 0 = read
//   m0_addr      master 0 byte address
//   m0_wdata     master 0 write data
//   m0_rdata     master 0 read data, non-zero only on its ready cycle
//   m1_*         same set of signals for master 1
//   s_valid      slave request
//   s_ready      slave completion strobe
//   s_wstrb      slave byte strobes (0 whenever s_valid = 0)
//   s_addr       slave address (granted master's address while busy)
//   s_wdata      slave write data (granted master's data while busy)
//   s_rdata      slave read data
//   grant        index of the currently / most recently granted master
//   busy         high while a transaction is in flight
//   timeout_err  one-cycle pulse when a transaction is force-completed
//
// Parameters
//   TIMEOUT_CYCLES  number of busy cycles without s_ready before the
//                   transaction is forced to complete; 0 disables it
//   TIMEOUT_RDATA   read data returned on a timed-out transaction
// ----------------------------------------------------------------------------
module iomem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,

    output logic        grant,
    output logic        busy,
    output logic        timeout_err
);

    // ------------------------------------------------------------------------
    // Watchdog counter sizing. At least 9 bits so that the default of 256
    // always fits, wider if a larger timeout is requested.
    // ------------------------------------------------------------------------
    localparam int CNT_REQ_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W     = (CNT_REQ_W > 9) ? CNT_REQ_W : 9;

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    // Counter value seen on the last permitted busy cycle. The first busy
    // cycle has count 0, so cycle N has count N-1.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT_EN ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Completion of the granted transaction (normal or forced) and the
    // read word handed back with it.
    logic             done;
    logic [31:0]      done_rdata;

    // Request of the granted master.
    logic             sel_valid;
    logic [3:0]       sel_wstrb;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             timeout_hit;

    assign sel_valid = grant_q ? m1_valid : m0_valid;
    assign sel_wstrb = grant_q ? m1_wstrb : m0_wstrb;
    assign sel_addr  = grant_q ? m1_addr  : m0_addr;
    assign sel_wdata = grant_q ? m1_wdata : m0_wdata;

    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would let order of statements leak into
    // the hardware and mismatch simulation against synthesis.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            // Pretend m1 won last so m0 takes the first contested grant.
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and bus-side outputs
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; any path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        s_valid      = 1'b0;
        s_wstrb      = 4'b0000;
        s_addr       = 32'h0;
        s_wdata      = 32'h0;
        done         = 1'b0;
        done_rdata   = 32'h0;
        timeout_err  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    // Contested: alternate. Uncontested: whoever asks.
                    if (m0_valid && m1_valid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = m1_valid;
                    end
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                s_addr  = sel_addr;
                s_wdata = sel_wdata;

                if (!sel_valid) begin
                    // Master withdrew its request: drop it silently.
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else if (s_ready) begin
                    // A slave answer on the timeout cycle still counts as a
                    // normal completion, so this test comes first.
                    s_valid      = 1'b1;
                    s_wstrb      = sel_wstrb;
                    done         = 1'b1;
                    done_rdata   = s_rdata;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else if (timeout_hit) begin
                    // Withdraw the request from the slave and complete the
                    // master with the error word.
                    done         = 1'b1;
                    done_rdata   = TIMEOUT_RDATA;
                    timeout_err  = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    s_valid = 1'b1;
                    s_wstrb = sel_wstrb;
                    if (TIMEOUT_EN) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Master-side outputs. Read data is forced to zero outside the owning
    // master's ready cycle so idle masters never see stale slave data.
    // ------------------------------------------------------------------------
    assign m0_ready = done & ~grant_q;
    assign m1_ready = done &  grant_q;
    assign m0_rdata = m0_ready ? done_rdata : 32'h0;
    assign m1_rdata = m1_ready ? done_rdata : 32'h0;

    assign grant = grant_q;
    assign busy  = (state_q == BUSY);

endmodule

// File: tb/tb_iomem_arbiter.sv
// ----------------------------------------------------------------------------
// Directed testbench for iomem_arbiter, built with an 8-cycle watchdog.
// Inputs change on the falling clock edge; outputs are sampled 1 time unit
// later, well away from the rising edge that advances the arbiter.
// ----------------------------------------------------------------------------
module tb_iomem_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m0_ready;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_valid, m1_ready;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        grant, busy, timeout_err;

    int checks = 0;
    int errors = 0;

    iomem_arbiter #(
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m0_valid   (m0_valid),
        .m0_ready   (m0_ready),
        .m0_wstrb   (m0_wstrb),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_rdata   (m0_rdata),
        .m1_valid   (m1_valid),
        .m1_ready   (m1_ready),
        .m1_wstrb   (m1_wstrb),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_rdata   (m1_rdata),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_wstrb    (s_wstrb),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .grant      (grant),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Hard stop in case something stalls the directed sequence.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    int m0_cnt, m1_cnt;

    initial begin
        resetn   = 1'b0;
        m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        s_ready  = 1'b0; s_rdata  = 32'h0;

        // ---------------- reset state ----------------
        #2;
        check("rst_s_valid", s_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_m0_ready", m0_ready, 0);
        check("rst_m1_ready", m1_ready, 0);
        check("rst_timeout", timeout_err, 0);
        step(); resetn = 1'b1;

        // ---------------- test 1: reset mid-transaction ----------------
        step(); m0_valid = 1'b1; m0_addr = 32'h0300_0000; #1;
        check("t1_idle_busy", busy, 0);
        check("t1_idle_s_valid", s_valid, 0);
        step(); #1;
        check("t1_busy", busy, 1);
        check("t1_s_valid", s_valid, 1);
        check("t1_s_addr", s_addr, 32'h0300_0000);
        resetn = 1'b0; #1;
        check("t1_rst_s_valid", s_valid, 0);
        check("t1_rst_busy", busy, 0);
        check("t1_rst_grant", grant, 0);
        check("t1_rst_m0_ready", m0_ready, 0);
        check("t1_rst_m1_ready", m1_ready, 0);
        check("t1_rst_s_addr", s_addr, 0);
        check("t1_rst_s_wstrb", s_wstrb, 0);
        step(); resetn = 1'b1; #1;
        check("t1_rel_busy", busy, 0);
        step(); s_ready = 1'b1; s_rdata = 32'h1111_2222; #1;
        check("t1_m0_ready", m0_ready, 1);
        check("t1_m0_rdata", m0_rdata, 32'h1111_2222);
        step(); m0_valid = 1'b0; s_ready = 1'b0; #1;
        check("t1_after_ready", m0_ready, 0);
        check("t1_after_busy", busy, 0);

        // ---------------- test 2: single m0 read, slave ready on 3rd cycle ----------------
        step(); m0_valid = 1'b1; m0_addr = 32'h0300_0010; m0_wstrb = 4'h0; #1;
        check("t2_s_valid_c0", s_valid, 0);
        for (int c = 1; c <= 2; c++) begin
            step(); #1;
            check("t2_s_valid_wait", s_valid, 1);
            check("t2_s_addr", s_addr, 32'h0300_0010);
            check("t2_s_wstrb", s_wstrb, 0);
            check("t2_m0_ready_wait", m0_ready, 0);
            check("t2_m0_rdata_wait", m0_rdata, 0);
        end
        step(); s_ready = 1'b1; s_rdata = 32'h1234_5678; #1;
        check("t2_m0_ready", m0_ready, 1);
        check("t2_m0_rdata", m0_rdata, 32'h1234_5678);
        check("t2_m1_ready", m1_ready, 0);
        check("t2_m1_rdata", m1_rdata, 0);
        step(); m0_valid = 1'b0; s_ready = 1'b0; #1;
        check("t2_m0_ready_off", m0_ready, 0);
        check("t2_s_valid_off", s_valid, 0);

        // ---------------- master abort ----------------
        step(); m0_valid = 1'b1; m0_addr = 32'h0300_0040; #1;
        step(); #1;
        check("ab_s_valid", s_valid, 1);
        step(); m0_valid = 1'b0; s_ready = 1'b1; #1;
        check("ab_s_valid_drop", s_valid, 0);
        check("ab_m0_ready", m0_ready, 0);
        check("ab_busy", busy, 1);
        step(); s_ready = 1'b0; #1;
        check("ab_idle", busy, 0);

        // ---------------- test 4: m1 write ----------------
        step();
        m1_valid = 1'b1; m1_wstrb = 4'b0011; m1_wdata = 32'hAABB_CCDD; m1_addr = 32'h0300_0020; #1;
        check("t4_idle_wstrb", s_wstrb, 0);
        step(); s_ready = 1'b1; s_rdata = 32'h0BAD_0BAD; #1;
        check("t4_grant", grant, 1);
        check("t4_s_valid", s_valid, 1);
        check("t4_s_wstrb", s_wstrb, 4'b0011);
        check("t4_s_wdata", s_wdata, 32'hAABB_CCDD);
        check("t4_s_addr", s_addr, 32'h0300_0020);
        check("t4_m1_ready", m1_ready, 1);
        check("t4_m0_ready", m0_ready, 0);
        step(); m1_valid = 1'b0; m1_wstrb = 4'h0; s_ready = 1'b0; #1;
        check("t4_m1_ready_off", m1_ready, 0);

        // ---------------- test 3: both masters, back-to-back x4 ----------------
        m0_cnt = 0; m1_cnt = 0;
        step();
        m0_valid = 1'b1; m0_addr = 32'h0300_0100;
        m1_valid = 1'b1; m1_addr = 32'h0300_0200;
        s_ready = 1'b1; s_rdata = 32'h0000_00A5;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            #1;
            if (i % 2 == 0) begin
                check("t3_idle_gap", s_valid, 0);
            end else begin
                check("t3_s_valid", s_valid, 1);
                check("t3_grant", grant, ((i - 1) / 2) % 2);
                check("t3_s_addr", s_addr, (((i - 1) / 2) % 2 == 0) ? 32'h0300_0100 : 32'h0300_0200);
            end
            if (m0_ready) m0_cnt++;
            if (m1_ready) m1_cnt++;
        end
        check("t3_m0_count", m0_cnt, 2);
        check("t3_m1_count", m1_cnt, 2);
        step(); m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; #1;

        // ---------------- test 5: timeout, then m1 served ----------------
        step(); m0_valid = 1'b1; m0_addr = 32'h0300_0300; #1;
        check("t5_idle", busy, 0);
        for (int c = 1; c <= 7; c++) begin
            step(); #1;
            check("t5_wait_s_valid", s_valid, 1);
            check("t5_wait_ready", m0_ready, 0);
            check("t5_wait_terr", timeout_err, 0);
        end
        step(); #1;
        check("t5_to_ready", m0_ready, 1);
        check("t5_to_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("t5_to_terr", timeout_err, 1);
        check("t5_to_s_valid", s_valid, 0);
        check("t5_to_m1_ready", m1_ready, 0);
        step(); m0_valid = 1'b0; m1_valid = 1'b1; m1_addr = 32'h0300_0400; #1;
        check("t5_terr_pulse", timeout_err, 0);
        check("t5_post_busy", busy, 0);
        step(); s_ready = 1'b1; s_rdata = 32'h55AA_55AA; #1;
        check("t5_m1_grant", grant, 1);
        check("t5_m1_ready", m1_ready, 1);
        check("t5_m1_rdata", m1_rdata, 32'h55AA_55AA);
        check("t5_m1_terr", timeout_err, 0);
        step(); m1_valid = 1'b0; s_ready = 1'b0; #1;

        // ---------------- test 6: s_ready on the timeout cycle ----------------
        step(); m0_valid = 1'b1; m0_addr = 32'h0300_0500; #1;
        for (int c = 1; c <= 7; c++) begin
            step(); #1;
            check("t6_wait_ready", m0_ready, 0);
        end
        step(); s_ready = 1'b1; s_rdata = 32'hCAFE_F00D; #1;
        check("t6_ready", m0_ready, 1);
        check("t6_rdata", m0_rdata, 32'hCAFE_F00D);
        check("t6_terr", timeout_err, 0);
        check("t6_s_valid", s_valid, 1);
        step(); m0_valid = 1'b0; s_ready = 1'b0; #1;
        check("t6_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
